user_gpio_in_debounce: RTL and testbench
========================================

// Module: user_gpio_in_debounce
// PURPOSE
// - Receive-side conditioner for the FPGA input pin feeding the Zynq GPIO read path.
// - Synchronises the raw pin and debounces it. Drives the stable level to the Zynq.
// - Produces one-cycle edge strobes and a sticky, edge-selectable interrupt flag.
// - Sits between the pin and zynq_gpio_input, in place of the raw wire.
// PARAMETERS
// - SYNC_STAGES      2    synchroniser flop count, >=2
// - DEBOUNCE_CYCLES  4    consecutive equal samples required to accept a new level, >=2
// - CNT_W            16   debounce counter width; 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
// - clk              in   1   single system clock; all logic is rising-edge
// - rst              in   1   synchronous, active-high reset
// - gpio_input       in   1   raw FPGA pin, asynchronous to clk
// - irq_edge_sel     in   2   00 none, 01 rise, 10 fall, 11 both
// - irq_clr          in   1   one-cycle clear of irq
// - zynq_gpio_input  out  1   debounced level, to Zynq read
// - rise_pulse       out  1   one-cycle strobe on accepted 0->1
// - fall_pulse       out  1   one-cycle strobe on accepted 1->0
// - irq              out  1   sticky interrupt flag
// - edge_count       out  16  accepted rising edges (only with GPIO_EDGE_COUNT_EN)
// - cnt_clr          in   1   clears edge_count (only with GPIO_EDGE_COUNT_EN)
// BEHAVIOUR
// - Reset values: all synchroniser flops 0, level 0, state ST_STABLE, cnt 0.
// - Reset values: rise_pulse 0, fall_pulse 0, irq 0, edge_count 0.
// - Synchroniser: SYNC_STAGES-flop shift chain on gpio_input. Its last stage is s.
// - FSM, state ST_STABLE:
//   - s!=level -> go to ST_CHECK, cnt<=1.
//   - Otherwise stay, cnt<=0.
// - FSM, state ST_CHECK:
//   - s==level -> go to ST_STABLE, cnt<=0. Glitch is rejected; no strobe is produced.
//   - Else cnt==DEBOUNCE_CYCLES-1 -> level<=s, go to ST_STABLE, cnt<=0 (accept).
//   - Else cnt<=cnt+1.
// - Latency: count the first edge that samples the new pin value as edge 1.
//   - level changes on edge SYNC_STAGES+DEBOUNCE_CYCLES.
//   - Default parameters: edge 6.
// - Pin pulses shorter than DEBOUNCE_CYCLES clocks (after synchronisation) never change level.
// - rise_pulse/fall_pulse are registered on the same edge as the level update.
//   - They are high exactly in the first cycle in which the new level is visible.
//   - They are never high together.
// - irq set condition: (rise_pulse & sel[0]) | (fall_pulse & sel[1]).
//   - The set condition is evaluated from the strobe-producing update, so irq rises together with the strobe.
// - irq_clr clears irq on the next edge.
// - Set and clear in the same cycle: set wins, so no event is lost.
// - Changing irq_edge_sel never sets or clears irq by itself.
// - Reset mid-debounce: state aborts to ST_STABLE, level 0.
//   - If the pin is held high through reset, a full debounce follows.
//   - The resulting rise_pulse and irq (if enabled) are required behaviour.
// CONFIGURATION
// - Macro: GPIO_EDGE_COUNT_EN.
// - Defined:
//   - Ports edge_count and cnt_clr exist.
//   - edge_count increments on each rise_pulse and wraps 16'hFFFF -> 16'h0000.
//   - cnt_clr zeroes it on the next edge.
//   - cnt_clr together with rise_pulse gives 1.
// - Undefined: both ports and the counter logic are absent. All other behaviour is identical.
// TESTING (default parameters unless noted)
// - Reset, then pin held 0 for 50 cycles.
//   -> zynq_gpio_input=0, no strobes, irq=0.
// - sel=01; pin 0->1 before edge 1, held high.
//   -> level 1 at edge 6; rise_pulse high one cycle; irq=1.
//   - irq_clr pulse -> irq=0 next cycle.
// - Pin high for exactly 3 sampled cycles, then low.
//   -> level stays 0, no strobe, FSM back in ST_STABLE with cnt=0.
// - sel=10; accepted fall coincident with irq_clr=1.
//   -> irq remains 1; fall_pulse=1 one cycle.
// - rst asserted 2 cycles into ST_CHECK of a rising transition.
//   -> all outputs 0 next edge.
//   - With the pin still high after release: rise_pulse after 6 more edges.
// - With GPIO_EDGE_COUNT_EN:
//   - Preload via 65535 accepted rises, one more rise -> edge_count=0.
//   - cnt_clr with a simultaneous rise -> edge_count=1.

Source files
------------

// File: rtl/user_gpio_in_debounce.sv
// user_gpio_in_debounce
//
// Receive-side conditioner that sits between an FPGA input pin and the
// Zynq GPIO read path. The pin is synchronised, then debounced. The
// accepted level drives zynq_gpio_input.
//
// Extra outputs:
//   - one-cycle edge strobes
//   - a sticky interrupt flag whose trigger edge is selectable
//
// Optional feature (macro GPIO_EDGE_COUNT_EN):
//   - adds a 16-bit counter of accepted rising edges
//   - adds a clear input for that counter
//
// Ports:
//   clk              in   system clock, all logic on the rising edge
//   rst              in   synchronous active-high reset
//   gpio_input       in   raw pin, asynchronous to clk
//   irq_edge_sel     in   [1:0] 00 none, 01 rise, 10 fall, 11 both
//   irq_clr          in   clears irq on the next edge (a set in the same cycle wins)
//   cnt_clr          in   clears edge_count (GPIO_EDGE_COUNT_EN only)
//   edge_count       out  [15:0] accepted rising edges (GPIO_EDGE_COUNT_EN only)
//   zynq_gpio_input  out  debounced level
//   rise_pulse       out  one-cycle strobe on accepted 0->1
//   fall_pulse       out  one-cycle strobe on accepted 1->0
//   irq              out  sticky interrupt flag

module user_gpio_in_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gpio_input,
    input  logic [1:0]  irq_edge_sel,
    input  logic        irq_clr,
`ifdef GPIO_EDGE_COUNT_EN
    input  logic        cnt_clr,
    output logic [15:0] edge_count,
`endif
    output logic        zynq_gpio_input,
    output logic        rise_pulse,
    output logic        fall_pulse,
    output logic        irq
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic                   level;
    logic                   accept;
    logic                   rise_next, fall_next;
    logic                   irq_set;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], gpio_input};
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = '0;
        accept     = 1'b0;
        case (state)
            ST_STABLE: begin
                if (s != level) begin
                    state_next = ST_CHECK;
                    cnt_next   = CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (s == level) begin
                    // glitch rejected, counter restarts from zero
                    state_next = ST_STABLE;
                end else if (cnt == CNT_LAST) begin
                    accept     = 1'b1;
                    state_next = ST_STABLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = ST_STABLE;
        endcase

        // The strobes and the irq set term come from the accepting update
        // itself. They therefore register on the same edge as the level.
        rise_next = accept & s;
        fall_next = accept & ~s;
        irq_set   = (rise_next & irq_edge_sel[0]) | (fall_next & irq_edge_sel[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_STABLE;
            cnt        <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            irq        <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            if (accept) begin
                level <= s;
            end
            rise_pulse <= rise_next;
            fall_pulse <= fall_next;
            // set has priority over clear so that no event is lost
            if (irq_set) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end
        end
    end

    assign zynq_gpio_input = level;

`ifdef GPIO_EDGE_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_count <= '0;
        end else if (cnt_clr) begin
            // a rise in the clear cycle is still counted
            edge_count <= rise_next ? 16'd1 : 16'd0;
        end else if (rise_next) begin
            edge_count <= edge_count + 16'd1;
        end
    end
`else
    // edge counter not built
`endif

endmodule

// File: tb/tb_user_gpio_in_debounce.sv
module tb_user_gpio_in_debounce;

    localparam int SYNC    = 2;
    localparam int DEB     = 4;
    localparam int LATENCY = SYNC + DEB;

    logic        clk = 1'b0;
    logic        rst;
    logic        gpio_input;
    logic [1:0]  irq_edge_sel;
    logic        irq_clr;
    logic        zynq_gpio_input;
    logic        rise_pulse;
    logic        fall_pulse;
    logic        irq;
`ifdef GPIO_EDGE_COUNT_EN
    logic        cnt_clr;
    logic [15:0] edge_count;
`endif

    always #5 clk = ~clk;

    user_gpio_in_debounce #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .gpio_input      (gpio_input),
        .irq_edge_sel    (irq_edge_sel),
        .irq_clr         (irq_clr),
`ifdef GPIO_EDGE_COUNT_EN
        .cnt_clr         (cnt_clr),
        .edge_count      (edge_count),
`endif
        .zynq_gpio_input (zynq_gpio_input),
        .rise_pulse      (rise_pulse),
        .fall_pulse      (fall_pulse),
        .irq             (irq)
    );

    typedef struct packed {
        logic        level;
        logic        rise;
        logic        fall;
        logic        irq;
        logic [15:0] count;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model.
    // The sampled pin is seen SYNC edges later (a queue preloaded with
    // zeros at reset). The level flips when the last DEB seen samples all
    // differ from it.
    initial begin : model
        bit          dly[$];
        bit          win[$];
        bit          m_level;
        bit          m_irq;
        logic [15:0] m_count;
        bit          seen, acc, rise, fall;
        exp_t        e;
        m_level = 0;
        m_irq   = 0;
        m_count = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                dly.delete();
                for (int i = 0; i < SYNC; i++) dly.push_back(1'b0);
                win.delete();
                m_level = 0;
                m_irq   = 0;
                m_count = '0;
                rise    = 0;
                fall    = 0;
            end else begin
                seen = dly.pop_front();
                dly.push_back(gpio_input);
                win.push_back(seen);
                if (win.size() > DEB) void'(win.pop_front());
                acc = (win.size() == DEB);
                foreach (win[i]) if (win[i] == m_level) acc = 0;
                rise = acc && !m_level;
                fall = acc && m_level;
                if (acc) m_level = !m_level;
                if ((rise && irq_edge_sel[0]) || (fall && irq_edge_sel[1])) m_irq = 1;
                else if (irq_clr) m_irq = 0;
`ifdef GPIO_EDGE_COUNT_EN
                if (cnt_clr) m_count = rise ? 16'd1 : 16'd0;
                else if (rise) m_count = m_count + 16'd1;
`endif
            end
            e.level = m_level;
            e.rise  = rise;
            e.fall  = fall;
            e.irq   = m_irq;
            e.count = m_count;
            sb.push_back(e);
        end
    end

    // Monitor: compares the registered outputs against the scoreboard
    // in the middle of each cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
            end else begin
                e = sb.pop_front();
                check("level", int'(zynq_gpio_input), int'(e.level));
                check("rise_pulse", int'(rise_pulse), int'(e.rise));
                check("fall_pulse", int'(fall_pulse), int'(e.fall));
                check("irq", int'(irq), int'(e.irq));
                check("strobes_exclusive", int'(rise_pulse & fall_pulse), 0);
`ifdef GPIO_EDGE_COUNT_EN
                check("edge_count", int'(edge_count), int'(e.count));
`endif
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts posedges until the watched output goes high (bounded).
    // Returns -1 if the output never rises. Ends realigned on a negedge.
    task automatic edges_until(input bit watch_rise, output int edges);
        edges = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if ((watch_rise ? rise_pulse : zynq_gpio_input) == 1'b1) begin
                edges = k;
                break;
            end
        end
        @(negedge clk);
    endtask

    initial begin : stimulus
        int   lat;
        int   run;
        rst          = 1'b1;
        gpio_input   = 1'b0;
        irq_edge_sel = 2'b00;
        irq_clr      = 1'b0;
`ifdef GPIO_EDGE_COUNT_EN
        cnt_clr      = 1'b0;
`endif
        cyc(3);
        rst = 1'b0;
        cyc(50);

        // rising edge with sel=01; level visible on edge SYNC+DEB
        irq_edge_sel = 2'b01;
        gpio_input   = 1'b1;
        edges_until(1'b0, lat);
        check("rise_latency", lat, LATENCY);
        cyc(4);
        irq_clr = 1'b1;
        cyc(1);
        irq_clr = 1'b0;
        cyc(3);
        gpio_input = 1'b0;
        cyc(10);

        // pulses of 1..3 cycles are rejected; 4 cycles are accepted
        for (int w = 1; w <= DEB; w++) begin
            gpio_input = 1'b1;
            cyc(w);
            gpio_input = 1'b0;
            cyc(10);
        end

        // sel=10; the accepted fall coincides with irq_clr, and the set wins
        irq_edge_sel = 2'b10;
        irq_clr      = 1'b1;
        cyc(1);
        irq_clr    = 1'b0;
        gpio_input = 1'b1;
        cyc(10);
        gpio_input = 1'b0;
        cyc(LATENCY - 1);
        irq_clr = 1'b1;
        cyc(1);
        irq_clr = 1'b0;
        check("irq_set_beats_clr", int'(irq), 1);
        check("fall_with_clr", int'(fall_pulse), 1);
        cyc(5);

        // reset two cycles into the debounce check of a rise, pin held high
        irq_edge_sel = 2'b01;
        gpio_input   = 1'b1;
        cyc(SYNC + 2);
        rst = 1'b1;
        cyc(1);
        check("rst_outputs", int'({zynq_gpio_input, rise_pulse, fall_pulse, irq}), 0);
        rst = 1'b0;
        edges_until(1'b1, lat);
        check("rise_after_reset", lat, LATENCY);
        cyc(5);

        // randomized runs against the model
        repeat (400) begin
            gpio_input = 1'($urandom_range(0, 1));
            run = $urandom_range(1, 8);
            for (int r = 0; r < run; r++) begin
                irq_clr = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 15) == 0) irq_edge_sel = 2'($urandom_range(0, 3));
                rst = ($urandom_range(0, 299) == 0);
`ifdef GPIO_EDGE_COUNT_EN
                cnt_clr = ($urandom_range(0, 19) == 0);
`endif
                cyc(1);
            end
        end
        rst     = 1'b0;
        irq_clr = 1'b0;
`ifdef GPIO_EDGE_COUNT_EN
        cnt_clr = 1'b0;
`endif
        cyc(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
